// File: rtl/lane_stage3_wq.sv
// lane_stage3_wq: lane stage-3 VRF write queue.
// Converts groupCounter into (vd, offset), buffers writes in a DEPTH-entry
// circular FIFO, and issues them to the VRF write port over ready/valid.
// Tracks outstanding writes per instructionIndex and reports occupancy.
// Optional write-merge into the youngest entry: define LANE_STAGE3_WQ_MERGE_EN.
module lane_stage3_wq #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int GROUP_WIDTH = 11,
  parameter int OFFSET_BITS = 7,
  parameter int VD_WIDTH    = 5,
  parameter int INST_IDX_W  = 3
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enqueue_valid,
  output logic                          enqueue_ready,
  input  logic [GROUP_WIDTH-1:0]        enqueue_bits_groupCounter,
  input  logic [DATA_WIDTH-1:0]         enqueue_bits_data,
  input  logic [DATA_WIDTH/8-1:0]       enqueue_bits_mask,
  input  logic [VD_WIDTH-1:0]           enqueue_bits_vd,
  input  logic [INST_IDX_W-1:0]         enqueue_bits_instructionIndex,
  input  logic                          enqueue_bits_last,
  input  logic                          vrfWriteRequest_ready,
  output logic                          vrfWriteRequest_valid,
  output logic [VD_WIDTH-1:0]           vrfWriteRequest_bits_vd,
  output logic [OFFSET_BITS-1:0]        vrfWriteRequest_bits_offset,
  output logic [DATA_WIDTH/8-1:0]       vrfWriteRequest_bits_mask,
  output logic [DATA_WIDTH-1:0]         vrfWriteRequest_bits_data,
  output logic                          vrfWriteRequest_bits_last,
  output logic [INST_IDX_W-1:0]         vrfWriteRequest_bits_instructionIndex,
  output logic [(1<<INST_IDX_W)-1:0]    instructionPending,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int NINST  = 1 << INST_IDX_W;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = $clog2(DEPTH);

  logic [VD_WIDTH-1:0]    vdMem   [DEPTH];
  logic [OFFSET_BITS-1:0] offMem  [DEPTH];
  logic [MASK_W-1:0]      maskMem [DEPTH];
  logic [DATA_WIDTH-1:0]  dataMem [DEPTH];
  logic                   lastMem [DEPTH];
  logic [INST_IDX_W-1:0]  idxMem  [DEPTH];

  logic [PTR_W-1:0]       head, tail, headNext, tailNext;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       instCnt [NINST];
  logic [NINST-1:0]       incVec, decVec;

  logic                   enqFire, deqFire, mergeHit, alloc;
  logic [VD_WIDTH-1:0]    enqVd;
  logic [OFFSET_BITS-1:0] enqOffset;

  // Upper groupCounter bits step the register index; the sum wraps at VD_WIDTH.
  assign enqVd     = enqueue_bits_vd + VD_WIDTH'(enqueue_bits_groupCounter >> OFFSET_BITS);
  assign enqOffset = enqueue_bits_groupCounter[OFFSET_BITS-1:0];

  assign enqueue_ready         = (count != CNT_W'(DEPTH));
  assign vrfWriteRequest_valid = (count != '0);
  assign enqFire               = enqueue_valid & enqueue_ready;
  assign deqFire               = vrfWriteRequest_valid & vrfWriteRequest_ready;
  assign occupancy             = count;

  assign headNext = (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
  assign tailNext = (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;

`ifdef LANE_STAGE3_WQ_MERGE_EN
  logic [PTR_W-1:0] tailPrev;
  assign tailPrev = (tail == '0) ? PTR_W'(DEPTH - 1) : tail - 1'b1;
  // Youngest entry must survive this cycle (not the sole entry being dequeued).
  assign mergeHit = enqFire && (count != '0) && !((count == CNT_W'(1)) && deqFire)
                    && (vdMem[tailPrev] == enqVd) && (offMem[tailPrev] == enqOffset)
                    && (idxMem[tailPrev] == enqueue_bits_instructionIndex)
                    && !lastMem[tailPrev];
`else
  assign mergeHit = 1'b0;
`endif

  assign alloc = enqFire & ~mergeHit;

  assign vrfWriteRequest_bits_vd               = vdMem[head];
  assign vrfWriteRequest_bits_offset           = offMem[head];
  assign vrfWriteRequest_bits_mask             = maskMem[head];
  assign vrfWriteRequest_bits_data             = dataMem[head];
  assign vrfWriteRequest_bits_last             = lastMem[head];
  assign vrfWriteRequest_bits_instructionIndex = idxMem[head];

  // Entry storage: fresh entry at tail, or fold a merge into the youngest entry.
  always_ff @(posedge clock) begin
    if (alloc) begin
      vdMem[tail]   <= enqVd;
      offMem[tail]  <= enqOffset;
      maskMem[tail] <= enqueue_bits_mask;
      dataMem[tail] <= enqueue_bits_data;
      lastMem[tail] <= enqueue_bits_last;
      idxMem[tail]  <= enqueue_bits_instructionIndex;
    end
`ifdef LANE_STAGE3_WQ_MERGE_EN
    else if (mergeHit) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (enqueue_bits_mask[b]) dataMem[tailPrev][b*8 +: 8] <= enqueue_bits_data[b*8 +: 8];
      end
      maskMem[tailPrev] <= maskMem[tailPrev] | enqueue_bits_mask;
      lastMem[tailPrev] <= enqueue_bits_last;
    end
`endif
  end

  // FIFO pointers and entry count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc)   tail <= tailNext;
      if (deqFire) head <= headNext;
      if (alloc && !deqFire)      count <= count + 1'b1;
      else if (!alloc && deqFire) count <= count - 1'b1;
    end
  end

  // Per-instruction increment/decrement requests for this cycle.
  always_comb begin
    incVec = '0;
    decVec = '0;
    if (alloc)   incVec[enqueue_bits_instructionIndex] = 1'b1;
    if (deqFire) decVec[idxMem[head]] = 1'b1;
  end

  // Outstanding-write counters per instructionIndex.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NINST; i++) instCnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NINST; i++) begin
        if (incVec[i] && !decVec[i])      instCnt[i] <= instCnt[i] + 1'b1;
        else if (decVec[i] && !incVec[i]) instCnt[i] <= instCnt[i] - 1'b1;
      end
    end
  end

  // Pending flag per instruction.
  always_comb begin
    instructionPending = '0;
    for (int unsigned i = 0; i < NINST; i++) instructionPending[i] = (instCnt[i] != '0);
  end

endmodule

// File: tb/tb_lane_stage3_wq.sv
// Testbench for lane_stage3_wq (DEPTH=5, DATA_WIDTH=64), scoreboard model
// built on a queue of pending writes. Merge expectations follow
// LANE_STAGE3_WQ_MERGE_EN when defined.
module tb_lane_stage3_wq;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int GW = 11;
  localparam int OB = 7;
  localparam int VW = 5;
  localparam int IW = 3;
  localparam int D  = 5;
  localparam int CW = $clog2(D + 1);
  localparam int NI = 1 << IW;

  typedef struct packed {
    logic [VW-1:0] vd;
    logic [OB-1:0] off;
    logic [MW-1:0] mask;
    logic [DW-1:0] data;
    logic          last;
    logic [IW-1:0] idx;
  } entry_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enqueue_valid = 1'b0;
  logic          enqueue_ready;
  logic [GW-1:0] enqueue_bits_groupCounter = '0;
  logic [DW-1:0] enqueue_bits_data = '0;
  logic [MW-1:0] enqueue_bits_mask = '0;
  logic [VW-1:0] enqueue_bits_vd = '0;
  logic [IW-1:0] enqueue_bits_instructionIndex = '0;
  logic          enqueue_bits_last = 1'b0;
  logic          vrfWriteRequest_ready = 1'b0;
  logic          vrfWriteRequest_valid;
  logic [VW-1:0] vrfWriteRequest_bits_vd;
  logic [OB-1:0] vrfWriteRequest_bits_offset;
  logic [MW-1:0] vrfWriteRequest_bits_mask;
  logic [DW-1:0] vrfWriteRequest_bits_data;
  logic          vrfWriteRequest_bits_last;
  logic [IW-1:0] vrfWriteRequest_bits_instructionIndex;
  logic [NI-1:0] instructionPending;
  logic [CW-1:0] occupancy;

  entry_t dutHead;
  entry_t q[$];
  int     errors = 0;
  int     checks = 0;

  lane_stage3_wq #(
    .DATA_WIDTH(DW), .DEPTH(D), .GROUP_WIDTH(GW),
    .OFFSET_BITS(OB), .VD_WIDTH(VW), .INST_IDX_W(IW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enqueue_valid(enqueue_valid),
    .enqueue_ready(enqueue_ready),
    .enqueue_bits_groupCounter(enqueue_bits_groupCounter),
    .enqueue_bits_data(enqueue_bits_data),
    .enqueue_bits_mask(enqueue_bits_mask),
    .enqueue_bits_vd(enqueue_bits_vd),
    .enqueue_bits_instructionIndex(enqueue_bits_instructionIndex),
    .enqueue_bits_last(enqueue_bits_last),
    .vrfWriteRequest_ready(vrfWriteRequest_ready),
    .vrfWriteRequest_valid(vrfWriteRequest_valid),
    .vrfWriteRequest_bits_vd(vrfWriteRequest_bits_vd),
    .vrfWriteRequest_bits_offset(vrfWriteRequest_bits_offset),
    .vrfWriteRequest_bits_mask(vrfWriteRequest_bits_mask),
    .vrfWriteRequest_bits_data(vrfWriteRequest_bits_data),
    .vrfWriteRequest_bits_last(vrfWriteRequest_bits_last),
    .vrfWriteRequest_bits_instructionIndex(vrfWriteRequest_bits_instructionIndex),
    .instructionPending(instructionPending),
    .occupancy(occupancy)
  );

  assign dutHead = {vrfWriteRequest_bits_vd, vrfWriteRequest_bits_offset,
                    vrfWriteRequest_bits_mask, vrfWriteRequest_bits_data,
                    vrfWriteRequest_bits_last, vrfWriteRequest_bits_instructionIndex};

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Expected entry straight from the addressing rules.
  function automatic entry_t mkEntry(input logic [VW-1:0] vd, input logic [GW-1:0] gc,
                                     input logic [DW-1:0] data, input logic [MW-1:0] mask,
                                     input logic [IW-1:0] idx, input logic last);
    entry_t e;
    e.vd   = VW'((int'(vd) + int'(gc >> OB)) % (1 << VW));
    e.off  = OB'(int'(gc) % (1 << OB));
    e.mask = mask;
    e.data = data;
    e.last = last;
    e.idx  = idx;
    return e;
  endfunction

  function automatic logic [NI-1:0] modelPending();
    logic [NI-1:0] p;
    p = '0;
    foreach (q[k]) p[q[k].idx] = 1'b1;
    return p;
  endfunction

  // Drive one cycle of inputs and advance the model over the same clock edge.
  task automatic step(input logic v, input logic [VW-1:0] vd, input logic [GW-1:0] gc,
                      input logic [DW-1:0] data, input logic [MW-1:0] mask,
                      input logic [IW-1:0] idx, input logic last, input logic rdy);
    logic   enq, deq, merged;
    entry_t e, y;
    enqueue_valid                 = v;
    enqueue_bits_vd               = vd;
    enqueue_bits_groupCounter     = gc;
    enqueue_bits_data             = data;
    enqueue_bits_mask             = mask;
    enqueue_bits_instructionIndex = idx;
    enqueue_bits_last             = last;
    vrfWriteRequest_ready         = rdy;
    enq = v && (q.size() != D);
    deq = rdy && (q.size() != 0);
    e = mkEntry(vd, gc, data, mask, idx, last);
    @(posedge clock);
    if (deq) void'(q.pop_front());
    if (enq) begin
      merged = 1'b0;
`ifdef LANE_STAGE3_WQ_MERGE_EN
      if (q.size() != 0) begin
        y = q[q.size()-1];
        if (y.vd == e.vd && y.off == e.off && y.idx == e.idx && !y.last) begin
          for (int b = 0; b < MW; b++)
            if (e.mask[b]) y.data[b*8 +: 8] = e.data[b*8 +: 8];
          y.mask = y.mask | e.mask;
          y.last = e.last;
          q[q.size()-1] = y;
          merged = 1'b1;
        end
      end
`endif
      if (!merged) q.push_back(e);
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, '0, '0, '0, 1'b0, rdy);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++; if (vrfWriteRequest_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", vrfWriteRequest_valid); end
    checks++; if (enqueue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", enqueue_ready); end
    checks++; if (occupancy !== CW'(0)) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (instructionPending !== NI'(0)) begin errors++; $display("FAIL reset_pending got %h exp 00", instructionPending); end
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1'b0);
    idle(1'b0);
    checks++; if (vrfWriteRequest_valid !== 1'b0 || occupancy !== CW'(0)) begin errors++; $display("FAIL idle_state got valid=%b occ=%0d exp 0/0", vrfWriteRequest_valid, occupancy); end
  endtask

  task automatic test_basic();
    step(1'b1, 5'd30, 11'h305, 64'hDEADBEEF, 8'h0F, 3'd2, 1'b1, 1'b0);
    checks++; if (vrfWriteRequest_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", vrfWriteRequest_valid); end
    checks++; if (vrfWriteRequest_bits_vd !== 5'd4) begin errors++; $display("FAIL basic_vd got %0d exp 4", vrfWriteRequest_bits_vd); end
    checks++; if (vrfWriteRequest_bits_offset !== 7'd5) begin errors++; $display("FAIL basic_offset got %0d exp 5", vrfWriteRequest_bits_offset); end
    checks++; if (vrfWriteRequest_bits_data !== 64'hDEADBEEF || vrfWriteRequest_bits_last !== 1'b1) begin errors++; $display("FAIL basic_data got %h/%b exp deadbeef/1", vrfWriteRequest_bits_data, vrfWriteRequest_bits_last); end
    checks++; if (instructionPending !== 8'h04) begin errors++; $display("FAIL basic_pending got %h exp 04", instructionPending); end
    checks++; if (dutHead !== q[0]) begin errors++; $display("FAIL basic_head got %h exp %h", dutHead, q[0]); end
    idle(1'b1);
    checks++; if (vrfWriteRequest_valid !== 1'b0 || instructionPending !== 8'h00) begin errors++; $display("FAIL basic_drain got valid=%b pend=%h exp 0/00", vrfWriteRequest_valid, instructionPending); end
  endtask

  task automatic test_full();
    logic [DW-1:0] heldData;
    logic          held, acc;
    heldData = {$urandom, $urandom};
    for (int i = 0; i <= D; i++) begin
      step(1'b1, '0, GW'(i), (i == D) ? heldData : {$urandom, $urandom}, 8'hFF, IW'(i % NI), 1'b0, 1'b0);
      checks++; if (enqueue_ready !== (i + 1 < D)) begin errors++; $display("FAIL full_ready[%0d] got %b exp %b", i, enqueue_ready, (i + 1 < D)); end
    end
    checks++; if (occupancy !== CW'(D)) begin errors++; $display("FAIL full_occ got %0d exp %0d", occupancy, D); end
    checks++; if (dutHead !== q[0]) begin errors++; $display("FAIL full_hold_head got %h exp %h", dutHead, q[0]); end
    held = 1'b1;
    for (int k = 0; k < 4 * D && (q.size() != 0 || held); k++) begin
      acc = held && (q.size() != D);
      step(held, '0, GW'(D), heldData, 8'hFF, IW'(D % NI), 1'b0, 1'b1);
      if (acc) held = 1'b0;
      if (k == 0) begin
        checks++; if (occupancy !== CW'(D - 1)) begin errors++; $display("FAIL full_refuse got occ=%0d exp %0d", occupancy, D - 1); end
      end
      checks++; if (occupancy !== CW'(q.size())) begin errors++; $display("FAIL drain_occ got %0d exp %0d", occupancy, q.size()); end
      if (q.size() != 0) begin
        checks++; if (dutHead !== q[0]) begin errors++; $display("FAIL drain_head got %h exp %h", dutHead, q[0]); end
      end
    end
    checks++; if (q.size() != 0 || held || vrfWriteRequest_valid !== 1'b0) begin errors++; $display("FAIL drain_done got valid=%b exp 0 (model left %0d)", vrfWriteRequest_valid, q.size()); end
  endtask

  task automatic test_same_idx();
    step(1'b1, 5'd1, 11'd1, 64'h11, 8'h01, 3'd1, 1'b0, 1'b0);
    step(1'b1, 5'd1, 11'd2, 64'h22, 8'h01, 3'd1, 1'b0, 1'b0);
    step(1'b1, 5'd1, 11'd3, 64'h33, 8'h01, 3'd1, 1'b0, 1'b1);
    checks++; if (occupancy !== CW'(2)) begin errors++; $display("FAIL same_idx_occ got %0d exp 2", occupancy); end
    checks++; if (instructionPending !== 8'h02) begin errors++; $display("FAIL same_idx_pend got %h exp 02", instructionPending); end
    idle(1'b1);
    checks++; if (instructionPending !== 8'h02 || dutHead !== q[0]) begin errors++; $display("FAIL same_idx_one got pend=%h head=%h exp 02/%h", instructionPending, dutHead, q[0]); end
    idle(1'b1);
    checks++; if (instructionPending !== 8'h00 || occupancy !== CW'(0)) begin errors++; $display("FAIL same_idx_empty got pend=%h occ=%0d exp 00/0", instructionPending, occupancy); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) step(1'b1, 5'd7, GW'(10 + i), {$urandom, $urandom}, 8'hF0, IW'(i + 4), 1'b0, 1'b0);
    checks++; if (occupancy !== CW'(3)) begin errors++; $display("FAIL mid_pre_occ got %0d exp 3", occupancy); end
    #2 reset = 1'b1;
    #1;
    q.delete();
    checks++; if (vrfWriteRequest_valid !== 1'b0 || occupancy !== CW'(0)) begin errors++; $display("FAIL mid_reset got valid=%b occ=%0d exp 0/0", vrfWriteRequest_valid, occupancy); end
    checks++; if (instructionPending !== 8'h00 || enqueue_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_flags got pend=%h rdy=%b exp 00/1", instructionPending, enqueue_ready); end
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1'b1);
    checks++; if (vrfWriteRequest_valid !== 1'b0) begin errors++; $display("FAIL mid_after got valid=%b exp 0", vrfWriteRequest_valid); end
  endtask

  task automatic test_merge();
    step(1'b1, 5'd3, 11'd7, 64'h0000AAAA, 8'h03, 3'd0, 1'b0, 1'b0);
    step(1'b1, 5'd3, 11'd7, 64'hBBBB0000, 8'h0C, 3'd0, 1'b0, 1'b0);
`ifdef LANE_STAGE3_WQ_MERGE_EN
    checks++; if (occupancy !== CW'(1)) begin errors++; $display("FAIL merge_occ got %0d exp 1", occupancy); end
    checks++; if (vrfWriteRequest_bits_mask !== 8'h0F || vrfWriteRequest_bits_data !== 64'hBBBBAAAA) begin errors++; $display("FAIL merge_head got mask=%h data=%h exp 0f/bbbbaaaa", vrfWriteRequest_bits_mask, vrfWriteRequest_bits_data); end
`else
    checks++; if (occupancy !== CW'(2)) begin errors++; $display("FAIL nomerge_occ got %0d exp 2", occupancy); end
    checks++; if (vrfWriteRequest_bits_mask !== 8'h03 || vrfWriteRequest_bits_data !== 64'h0000AAAA) begin errors++; $display("FAIL nomerge_head got mask=%h data=%h exp 03/0000aaaa", vrfWriteRequest_bits_mask, vrfWriteRequest_bits_data); end
`endif
    checks++; if (dutHead !== q[0]) begin errors++; $display("FAIL merge_model got %h exp %h", dutHead, q[0]); end
    idle(1'b1);
    idle(1'b1);
    checks++; if (vrfWriteRequest_valid !== 1'b0) begin errors++; $display("FAIL merge_drain got valid=%b exp 0", vrfWriteRequest_valid); end
  endtask

  task automatic test_random();
    logic          v, rdy, last;
    logic [VW-1:0] vd;
    logic [GW-1:0] gc;
    logic [IW-1:0] idx;
    for (int c = 0; c < 2000; c++) begin
      v    = ($urandom_range(0, 99) < 60);
      rdy  = ($urandom_range(0, 99) < 50);
      vd   = VW'($urandom_range(30, 31));
      gc   = GW'(($urandom_range(0, 3) << OB) | $urandom_range(0, 1));
      idx  = IW'($urandom_range(0, NI - 1));
      last = ($urandom_range(0, 3) == 0);
      step(v, vd, gc, {$urandom, $urandom}, MW'($urandom), idx, last, rdy);
      checks++; if (occupancy !== CW'(q.size()) || vrfWriteRequest_valid !== (q.size() != 0) || enqueue_ready !== (q.size() != D)) begin
        errors++; $display("FAIL rand_state[%0d] got occ=%0d v=%b r=%b exp occ=%0d", c, occupancy, vrfWriteRequest_valid, enqueue_ready, q.size());
      end
      checks++; if (instructionPending !== modelPending()) begin errors++; $display("FAIL rand_pend[%0d] got %h exp %h", c, instructionPending, modelPending()); end
      if (q.size() != 0) begin
        checks++; if (dutHead !== q[0]) begin errors++; $display("FAIL rand_head[%0d] got %h exp %h", c, dutHead, q[0]); end
      end
    end
    for (int k = 0; k < 2 * D && q.size() != 0; k++) begin
      idle(1'b1);
      if (q.size() != 0) begin
        checks++; if (dutHead !== q[0]) begin errors++; $display("FAIL rand_drain_head got %h exp %h", dutHead, q[0]); end
      end
    end
    checks++; if (q.size() != 0 || vrfWriteRequest_valid !== 1'b0 || instructionPending !== 8'h00) begin
      errors++; $display("FAIL rand_end got valid=%b pend=%h exp 0/00 (model left %0d)", vrfWriteRequest_valid, instructionPending, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_same_idx();
    test_reset_mid();
    test_merge();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
